// File: rtl/char_text_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : char_text_buffer
// Purpose  : Character-cell text store for the text overlay. Answers the
//            renderer's per-pixel (cell, font line) requests with the font row
//            of the stored character, and offers a cursor-driven write port
//            with CR/LF/BS handling and a hardware clear sequence.
// Ports    : pclk, rst (async, active high)
//            char_xy[15:8] column / [7:0] row, char_line -> char_pixels (2 cyc)
//            wr_valid/wr_data/wr_ready   : character/control write port
//            clr, cur_set/cur_x/cur_y    : clear pulse and cursor load
//            busy, cursor_x, cursor_y    : status
// Revision : 1.0 - initial release
// ============================================================================
module char_text_buffer #(
    parameter int         X_LETTERS = 16,
    parameter int         Y_LETTERS = 16,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [15:0] char_xy,
    input  logic [3:0]  char_line,
    output logic [7:0]  char_pixels,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        clr,
    input  logic        cur_set,
    input  logic [7:0]  cur_x,
    input  logic [7:0]  cur_y,
    output logic        busy,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y
);

    localparam int               c_xw   = $clog2(X_LETTERS);
    localparam int               c_yw   = $clog2(Y_LETTERS);
    localparam int               c_aw   = c_xw + c_yw;
    localparam int               c_cells = X_LETTERS * Y_LETTERS;
    localparam logic [c_aw-1:0]  c_last = c_aw'(c_cells - 1);
    localparam logic [7:0]       c_xmax = 8'(X_LETTERS - 1);
    localparam logic [7:0]       c_ymax = 8'(Y_LETTERS - 1);
    localparam logic [8:0]       c_xlim = 9'(X_LETTERS);
    localparam logic [8:0]       c_ylim = 9'(Y_LETTERS);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Character storage; contents deliberately have no reset.
    logic [7:0] mem [c_cells];

    state_t          state_q, state_d;
    logic [c_aw-1:0] count_q, count_d;
    logic [7:0]      cursor_x_q, cursor_x_d;
    logic [7:0]      cursor_y_q, cursor_y_d;
    logic [7:0]      code_q, code_d;
    logic [3:0]      line_q, line_d;
    logic            oor_q, oor_d;
    logic            oor2_q, oor2_d;

    logic            w_we;
    logic [c_aw-1:0] w_waddr;
    logic [7:0]      w_wdata;
    logic [7:0]      w_x_dec;
    logic [7:0]      w_y_inc;
    logic [7:0]      w_rom_data;
    logic [7:0]      w_col;
    logic [7:0]      w_row;
    logic            w_unused_ok;

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 here, stage 2 is the registered font ROM.
    // The combinational array read happens before this edge's write
    // lands, which gives read-first behaviour on an address collision.
    // ------------------------------------------------------------------
    always_comb begin
        w_col  = char_xy[15:8];
        w_row  = char_xy[7:0];
        code_d = mem[{w_row[c_yw-1:0], w_col[c_xw-1:0]}];
        line_d = char_line;
        oor_d  = ({1'b0, w_col} >= c_xlim) || ({1'b0, w_row} >= c_ylim);
        oor2_d = oor_q;
    end

    // Code bit 7 is not part of the font address.
    assign w_unused_ok = code_q[7];

    font_rom u_font_rom (
        .clk  (pclk),
        .rst  (rst),
        .addr ({code_q[6:0], line_q}),
        .data (w_rom_data)
    );

    assign char_pixels = oor2_q ? 8'h00 : w_rom_data;

    // ------------------------------------------------------------------
    // Control: clear sequencing, cursor and write decode.
    // ------------------------------------------------------------------
    assign busy     = (state_q == ST_CLEAR);
    assign wr_ready = (state_q == ST_IDLE) && !clr && !cur_set;
    assign cursor_x = cursor_x_q;
    assign cursor_y = cursor_y_q;

    assign w_x_dec = cursor_x_q - 8'd1;
    assign w_y_inc = (cursor_y_q == c_ymax) ? 8'd0 : cursor_y_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        w_we       = 1'b0;
        w_waddr    = {cursor_y_q[c_yw-1:0], cursor_x_q[c_xw-1:0]};
        w_wdata    = FILL_CHAR;

        case (state_q)
            ST_CLEAR: begin
                if (clr) begin
                    count_d = '0;
                end else begin
                    w_we    = 1'b1;
                    w_waddr = count_q;
                    if (count_q == c_last) begin
                        state_d    = ST_IDLE;
                        count_d    = '0;
                        cursor_x_d = 8'd0;
                        cursor_y_d = 8'd0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    count_d = '0;
                end else if (cur_set) begin
                    cursor_x_d = (cur_x > c_xmax) ? c_xmax : cur_x;
                    cursor_y_d = (cur_y > c_ymax) ? c_ymax : cur_y;
                end else if (wr_valid) begin
                    case (wr_data)
                        8'h0D: cursor_x_d = 8'd0;
                        8'h0A: begin
                            cursor_x_d = 8'd0;
                            cursor_y_d = w_y_inc;
                        end
                        8'h08: begin
                            // Backspace erases the cell it steps back onto.
                            if (cursor_x_q != 8'd0) begin
                                cursor_x_d = w_x_dec;
                                w_we       = 1'b1;
                                w_waddr    = {cursor_y_q[c_yw-1:0], w_x_dec[c_xw-1:0]};
                            end
                        end
                        default: begin
                            w_we    = 1'b1;
                            w_wdata = wr_data;
                            if (cursor_x_q == c_xmax) begin
                                cursor_x_d = 8'd0;
                                cursor_y_d = w_y_inc;
                            end else begin
                                cursor_x_d = cursor_x_q + 8'd1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            count_q    <= '0;
            cursor_x_q <= 8'd0;
            cursor_y_q <= 8'd0;
            code_q     <= 8'd0;
            line_q     <= 4'd0;
            oor_q      <= 1'b0;
            oor2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            code_q     <= code_d;
            line_q     <= line_d;
            oor_q      <= oor_d;
            oor2_q     <= oor2_d;
        end
    end

endmodule

// ============================================================================
// Module   : font_rom
// Purpose  : Registered 8x16 font lookup, addr = {code[6:0], line}.
//            Holds glyphs for space, 'A', 'B', 'C' and 'X'; any other code
//            returns the test pattern {code[3:0], line}.
// Ports    : clk, rst (async, active high), addr[10:0] -> data[7:0] (1 cyc)
// Revision : 1.0 - initial release
// ============================================================================
module font_rom (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [7:0]   data_q, data_d;
    logic [127:0] w_glyph;
    logic         w_known;
    logic [6:0]   w_sel;

    // Line 0 is the most significant byte of each glyph word.
    assign w_sel = {~addr[3:0], 3'b000};

    always_comb begin
        w_glyph = 128'h0;
        w_known = 1'b1;
        case (addr[10:4])
            7'h20:   w_glyph = 128'h0;
            7'h41:   w_glyph = 128'h0000_1038_6cc6_c6fe_c6c6_c6c6_0000_0000;
            7'h42:   w_glyph = 128'h0000_fc66_6666_7c66_6666_66fc_0000_0000;
            7'h43:   w_glyph = 128'h0000_3c66_c2c0_c0c0_c0c2_663c_0000_0000;
            7'h58:   w_glyph = 128'h0000_c6c6_6c7c_3838_7c6c_c6c6_0000_0000;
            default: w_known = 1'b0;
        endcase
        data_d = w_known ? w_glyph[w_sel +: 8] : {addr[7:4], addr[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule
`default_nettype wire
